// File: rtl/dau_pkg.sv
// Shared types and constants for the DAU output-stream arbiter.
package dau_pkg;

  localparam int DAU_DATA_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_AES = 2'd1,
    ST_GRANT_RSA = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_AES = 1'b0,
    SRC_RSA = 1'b1
  } dau_src_t;

  // Engine on the other side of the arbiter from the given one.
  function automatic dau_src_t other_src(input dau_src_t src);
    dau_src_t res;
    if (src == SRC_AES) begin
      res = SRC_RSA;
    end else begin
      res = SRC_AES;
    end
    return res;
  endfunction

endpackage

// File: rtl/dau_stream_arbiter_if.sv
// Handshake bundle between the AES/RSA result streams, the arbiter and the
// board-level output port. The arbiter uses the slave view.
interface dau_stream_arbiter_if
  import dau_pkg::*;
#(
  parameter int DATA_W = DAU_DATA_W
);

  logic              stall;
  logic              aes_valid_i;
  logic [DATA_W-1:0] aes_data_i;
  logic              aes_ready_o;
  logic              rsa_valid_i;
  logic [DATA_W-1:0] rsa_data_i;
  logic              rsa_ready_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_src_o;
  logic              out_valid_o;
  logic              out_ready_i;

  modport slave (
    input  stall,
    input  aes_valid_i,
    input  aes_data_i,
    output aes_ready_o,
    input  rsa_valid_i,
    input  rsa_data_i,
    output rsa_ready_o,
    output out_data_o,
    output out_src_o,
    output out_valid_o,
    input  out_ready_i
  );

  modport master (
    output stall,
    output aes_valid_i,
    output aes_data_i,
    input  aes_ready_o,
    output rsa_valid_i,
    output rsa_data_i,
    input  rsa_ready_o,
    input  out_data_o,
    input  out_src_o,
    input  out_valid_o,
    output out_ready_i
  );

endinterface

// File: rtl/dau_out_reg.sv
// One-entry output register: loads an accepted beat, clears valid when the
// downstream takes the beat without a replacement, otherwise holds.
module dau_out_reg
  import dau_pkg::*;
#(
  parameter int DATA_W = DAU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  dau_src_t          load_src,
  input  logic              take,
  output logic [DATA_W-1:0] q_data,
  output dau_src_t          q_src,
  output logic              q_valid
);

  logic [DATA_W-1:0] data_r;
  dau_src_t          src_r;
  logic              valid_r;

  // Load wins over drain so accept-and-drain in one cycle stays bubble-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r  <= {DATA_W{1'b0}};
      src_r   <= SRC_AES;
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= load_data;
      src_r   <= load_src;
      valid_r <= 1'b1;
    end else if (take) begin
      data_r  <= data_r;
      src_r   <= src_r;
      valid_r <= 1'b0;
    end else begin
      data_r  <= data_r;
      src_r   <= src_r;
      valid_r <= valid_r;
    end
  end

  assign q_data  = data_r;
  assign q_src   = src_r;
  assign q_valid = valid_r;

endmodule

// File: rtl/dau_stream_arbiter_chk.sv
// Invariants of the arbiter: exclusive grants, bounded burst counter and a
// stable output beat while the downstream applies backpressure.
module dau_stream_arbiter_chk #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 3,
  parameter int BURST  = 4
) (
  input logic              clk,
  input logic              rst,
  input logic              aes_ready,
  input logic              rsa_ready,
  input logic [CNT_W-1:0]  beat_cnt,
  input logic              out_valid,
  input logic              out_ready,
  input logic              out_src,
  input logic [DATA_W-1:0] out_data
);

  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  a_ready_excl: assert property (@(posedge clk) disable iff (!rst)
    !(aes_ready && rsa_ready));

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
    beat_cnt <= BURST_C);

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (out_valid && !out_ready) |=> (out_valid && $stable({out_src, out_data})));

endmodule

// File: rtl/dau_stream_arbiter.sv
// Round-robin arbiter sharing the DAU output stream between the AES and RSA
// result streams. A grant lasts up to BURST beats; every beat leaves through a
// one-entry output register tagged with its source engine.
module dau_stream_arbiter
  import dau_pkg::*;
#(
  parameter int DATA_W = DAU_DATA_W,
  parameter int BURST  = 4
) (
  input logic                 clk,
  input logic                 rst,
  dau_stream_arbiter_if.slave bus
);

  localparam int               CNT_W   = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  arb_state_t        state_r;
  logic [CNT_W-1:0]  beat_cnt_r;
  dau_src_t          last_src_r;

  logic              slot_free_s;
  logic              aes_ready_s;
  logic              rsa_ready_s;
  logic              aes_acc_s;
  logic              rsa_acc_s;
  logic              load_s;
  logic [DATA_W-1:0] load_data_s;
  dau_src_t          load_src_s;

  logic              own_valid_s;
  logic              own_acc_s;
  logic              other_valid_s;
  dau_src_t          own_src_s;
  arb_state_t        other_st_s;
  logic [CNT_W-1:0]  cnt_inc_s;

  logic [DATA_W-1:0] out_data_s;
  dau_src_t          out_src_s;
  logic              out_valid_s;

  // Ready follows the grant; it drops at once on stall or a full, blocked slot.
  always_comb begin
    slot_free_s = !out_valid_s || bus.out_ready_i;
    aes_ready_s = (state_r == ST_GRANT_AES) && slot_free_s && !bus.stall;
    rsa_ready_s = (state_r == ST_GRANT_RSA) && slot_free_s && !bus.stall;
    aes_acc_s   = bus.aes_valid_i && aes_ready_s;
    rsa_acc_s   = bus.rsa_valid_i && rsa_ready_s;
    load_s      = aes_acc_s || rsa_acc_s;
    if (rsa_acc_s) begin
      load_data_s = bus.rsa_data_i;
      load_src_s  = SRC_RSA;
    end else begin
      load_data_s = bus.aes_data_i;
      load_src_s  = SRC_AES;
    end
  end

  // View the active grant as "own" and "other" side so both grant states share one FSM arm.
  always_comb begin
    cnt_inc_s = beat_cnt_r + CNT_W'(1);
    case (state_r)
      ST_GRANT_AES: begin
        own_valid_s   = bus.aes_valid_i;
        own_acc_s     = aes_acc_s;
        other_valid_s = bus.rsa_valid_i;
        own_src_s     = SRC_AES;
        other_st_s    = ST_GRANT_RSA;
      end
      ST_GRANT_RSA: begin
        own_valid_s   = bus.rsa_valid_i;
        own_acc_s     = rsa_acc_s;
        other_valid_s = bus.aes_valid_i;
        own_src_s     = SRC_RSA;
        other_st_s    = ST_GRANT_AES;
      end
      default: begin
        own_valid_s   = 1'b0;
        own_acc_s     = 1'b0;
        other_valid_s = 1'b0;
        own_src_s     = SRC_AES;
        other_st_s    = ST_IDLE;
      end
    endcase
  end

  // Grant FSM: round-robin pick from IDLE, burst counting and rotation; frozen under stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      beat_cnt_r <= {CNT_W{1'b0}};
      last_src_r <= SRC_RSA;
    end else if (bus.stall) begin
      state_r    <= state_r;
      beat_cnt_r <= beat_cnt_r;
      last_src_r <= last_src_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          beat_cnt_r <= {CNT_W{1'b0}};
          if (bus.aes_valid_i && bus.rsa_valid_i) begin
            state_r <= (other_src(last_src_r) == SRC_AES) ? ST_GRANT_AES : ST_GRANT_RSA;
          end else if (bus.aes_valid_i) begin
            state_r <= ST_GRANT_AES;
          end else if (bus.rsa_valid_i) begin
            state_r <= ST_GRANT_RSA;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT_AES, ST_GRANT_RSA: begin
          if (own_acc_s) begin
            last_src_r <= own_src_s;
            if (cnt_inc_s == BURST_C) begin
              beat_cnt_r <= {CNT_W{1'b0}};
              state_r    <= other_valid_s ? other_st_s : state_r;
            end else begin
              beat_cnt_r <= cnt_inc_s;
            end
          end else if (!own_valid_s) begin
            beat_cnt_r <= {CNT_W{1'b0}};
            state_r    <= other_valid_s ? other_st_s : ST_IDLE;
          end else begin
            beat_cnt_r <= beat_cnt_r;
            state_r    <= state_r;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          beat_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  dau_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data (load_data_s),
    .load_src  (load_src_s),
    .take      (bus.out_ready_i),
    .q_data    (out_data_s),
    .q_src     (out_src_s),
    .q_valid   (out_valid_s)
  );

  dau_stream_arbiter_chk #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .BURST  (BURST)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .aes_ready (aes_ready_s),
    .rsa_ready (rsa_ready_s),
    .beat_cnt  (beat_cnt_r),
    .out_valid (out_valid_s),
    .out_ready (bus.out_ready_i),
    .out_src   (out_src_s),
    .out_data  (out_data_s)
  );

  assign bus.aes_ready_o = aes_ready_s;
  assign bus.rsa_ready_o = rsa_ready_s;
  assign bus.out_data_o  = out_data_s;
  assign bus.out_src_o   = out_src_s;
  assign bus.out_valid_o = out_valid_s;

endmodule

// File: tb/tb_dau_stream_arbiter.sv
// Directed bench for dau_stream_arbiter: reset, single-source streaming,
// round-robin bursts, backpressure, stall and asynchronous reset mid-burst.
module tb_dau_stream_arbiter;
  import dau_pkg::*;

  localparam int DW = 128;
  typedef logic [DW:0] word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dau_stream_arbiter_if #(.DATA_W(DW)) bus ();

  dau_stream_arbiter #(
    .DATA_W (DW),
    .BURST  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  word_t mon_beat[$];
  int    mon_cyc[$];
  word_t exp_q[$];

  logic          aes_en, rsa_en;
  int            aes_n, rsa_n, aes_lim, rsa_lim;
  logic [DW-1:0] aes_base, rsa_base;

  // Cycle stamp for gap detection.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every beat the downstream takes (handshake completes at the next rising edge).
  always @(negedge clk) begin
    if (rst && bus.out_valid_o && bus.out_ready_i) begin
      mon_beat.push_back({bus.out_src_o, bus.out_data_o});
      mon_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk(input logic src, input logic [DW-1:0] d);
    return {src, d};
  endfunction

  task automatic drive_src();
    bus.aes_valid_i = aes_en && (aes_n < aes_lim);
    bus.aes_data_i  = aes_base + DW'(aes_n);
    bus.rsa_valid_i = rsa_en && (rsa_n < rsa_lim);
    bus.rsa_data_i  = rsa_base + DW'(rsa_n);
  endtask

  // One clock: note handshakes just before the edge, advance the sources after it.
  task automatic tick();
    logic acc_a, acc_r;
    #1;
    acc_a = bus.aes_valid_i & bus.aes_ready_o;
    acc_r = bus.rsa_valid_i & bus.rsa_ready_o;
    @(posedge clk);
    #1;
    if (acc_a) aes_n++;
    if (acc_r) rsa_n++;
    drive_src();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    aes_en = 1'b0; rsa_en = 1'b0;
    aes_n = 0; rsa_n = 0; aes_lim = 0; rsa_lim = 0;
    aes_base = '0; rsa_base = '0;
    bus.stall = 1'b0;
    bus.out_ready_i = 1'b1;
    drive_src();
    repeat (3) @(posedge clk);
    #1;
    mon_beat.delete();
    mon_cyc.delete();
    rst = 1'b1;
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_count"}, word_t'(mon_beat.size()), word_t'(exp_q.size()));
    foreach (exp_q[i]) begin
      chk($sformatf("%s_beat%0d", tag, i), (i < mon_beat.size()) ? mon_beat[i] : '0, exp_q[i]);
    end
  endtask

  task automatic chk_no_gap(input string tag);
    if (mon_cyc.size() > 0) begin
      chk(tag, word_t'(mon_cyc[mon_cyc.size()-1] - mon_cyc[0]), word_t'(mon_cyc.size() - 1));
    end else begin
      chk(tag, word_t'(0), word_t'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 1: reset with both requesters valid, then AES wins the first tie.
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.out_ready_i = 1'b1;
    aes_en = 1'b1; rsa_en = 1'b1; aes_lim = 100; rsa_lim = 100;
    aes_n = 0; rsa_n = 0;
    aes_base = 128'h10; rsa_base = 128'h20;
    drive_src();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", word_t'(bus.out_valid_o), word_t'(1'b0));
    chk("rst_out_data", word_t'(bus.out_data_o), word_t'(0));
    chk("rst_aes_ready", word_t'(bus.aes_ready_o), word_t'(1'b0));
    chk("rst_rsa_ready", word_t'(bus.rsa_ready_o), word_t'(1'b0));
    rst = 1'b1;
    #1;
    chk("rel_idle_aes_ready", word_t'(bus.aes_ready_o), word_t'(1'b0));
    @(posedge clk);
    #1;
    chk("rel_aes_first", word_t'(bus.aes_ready_o), word_t'(1'b1));
    chk("rel_rsa_not", word_t'(bus.rsa_ready_o), word_t'(1'b0));

    // 2: AES only, beats 1..6, one-cycle latency.
    do_reset();
    aes_base = 128'h1; aes_lim = 6; aes_en = 1'b1;
    drive_src();
    #1;
    chk("aes_idle_ready", word_t'(bus.aes_ready_o), word_t'(1'b0));
    tick();
    chk("aes_ready_c2", word_t'(bus.aes_ready_o), word_t'(1'b1));
    chk("aes_out_empty", word_t'(bus.out_valid_o), word_t'(1'b0));
    tick();
    chk("aes_lat1_valid", word_t'(bus.out_valid_o), word_t'(1'b1));
    chk("aes_lat1_beat", {bus.out_src_o, bus.out_data_o}, mk(1'b0, 128'h1));
    repeat (8) tick();
    chk("aes_drained", word_t'(bus.out_valid_o), word_t'(1'b0));
    exp_q.delete();
    for (int i = 1; i <= 6; i++) exp_q.push_back(mk(1'b0, DW'(i)));
    chk_stream("aes_only");
    chk_no_gap("aes_only_gap");

    // 3: both valid, bursts of 4 rotate with no bubble.
    do_reset();
    aes_base = 128'h100; aes_lim = 8; aes_en = 1'b1;
    rsa_base = 128'h200; rsa_lim = 4; rsa_en = 1'b1;
    drive_src();
    repeat (16) tick();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 128'h100 + DW'(i)));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, 128'h200 + DW'(i)));
    for (int i = 4; i < 8; i++) exp_q.push_back(mk(1'b0, 128'h100 + DW'(i)));
    chk_stream("rr");
    chk_no_gap("rr_gap");

    // 4: backpressure holds 0xA5 for 5 cycles, then 0xA5 and 0xA6 leave.
    do_reset();
    aes_base = 128'hA5; aes_lim = 2; aes_en = 1'b1;
    drive_src();
    tick();
    tick();
    bus.out_ready_i = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k), word_t'(bus.out_valid_o), word_t'(1'b1));
      chk($sformatf("bp_data%0d", k), {bus.out_src_o, bus.out_data_o}, mk(1'b0, 128'hA5));
      chk($sformatf("bp_aes_ready%0d", k), word_t'(bus.aes_ready_o), word_t'(1'b0));
      chk($sformatf("bp_rsa_ready%0d", k), word_t'(bus.rsa_ready_o), word_t'(1'b0));
      tick();
    end
    bus.out_ready_i = 1'b1;
    repeat (4) tick();
    exp_q.delete();
    exp_q.push_back(mk(1'b0, 128'hA5));
    exp_q.push_back(mk(1'b0, 128'hA6));
    chk_stream("bp");

    // 5: stall at beat_cnt=2; output drains, burst resumes with 2 more AES beats.
    do_reset();
    aes_base = 128'h300; aes_lim = 8; aes_en = 1'b1;
    rsa_base = 128'h400; rsa_lim = 2; rsa_en = 1'b1;
    drive_src();
    tick();
    tick();
    tick();
    bus.stall = 1'b1;
    #1;
    chk("stall_aes_ready", word_t'(bus.aes_ready_o), word_t'(1'b0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_aes_ready%0d", k), word_t'(bus.aes_ready_o), word_t'(1'b0));
      chk($sformatf("stall_rsa_ready%0d", k), word_t'(bus.rsa_ready_o), word_t'(1'b0));
    end
    chk("stall_drained", word_t'(bus.out_valid_o), word_t'(1'b0));
    chk("stall_beats_so_far", word_t'(mon_beat.size()), word_t'(2));
    bus.stall = 1'b0;
    repeat (14) tick();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 128'h300 + DW'(i)));
    for (int i = 0; i < 2; i++) exp_q.push_back(mk(1'b1, 128'h400 + DW'(i)));
    for (int i = 4; i < 8; i++) exp_q.push_back(mk(1'b0, 128'h300 + DW'(i)));
    chk_stream("stall");

    // 6: asynchronous reset while a beat is held; that beat never appears.
    do_reset();
    aes_base = 128'h500; aes_lim = 8; aes_en = 1'b1;
    drive_src();
    tick();
    tick();
    tick();
    bus.out_ready_i = 1'b0;
    #1;
    chk("mid_held_valid", word_t'(bus.out_valid_o), word_t'(1'b1));
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", word_t'(bus.out_valid_o), word_t'(1'b0));
    chk("mid_rst_data", word_t'(bus.out_data_o), word_t'(0));
    chk("mid_rst_aes_ready", word_t'(bus.aes_ready_o), word_t'(1'b0));
    aes_en = 1'b0;
    drive_src();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready_i = 1'b1;
    repeat (4) tick();
    chk("mid_after_valid", word_t'(bus.out_valid_o), word_t'(1'b0));
    exp_q.delete();
    exp_q.push_back(mk(1'b0, 128'h500));
    chk_stream("mid_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
